// File: rtl/pong_pkg.sv
// Shared geometry, state encoding and position helpers for the pong game sequencer.
package pong_pkg;

    localparam int TOP_MARGIN    = 25;
    localparam int LEFT_HIT_X    = 41;
    localparam int RIGHT_HIT_X   = 592;
    localparam int BALL_Y_MIN    = 25;
    localparam int BALL_Y_MAX    = 472;
    localparam int PADDLE_Y_MAX  = 382;
    localparam int PADDLE_H      = 72;
    localparam int BALL_SIZE     = 8;
    localparam int CENTRE_X      = 316;
    localparam int CENTRE_Y      = 248;
    localparam int PADDLE_Y_INIT = 191;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        PLAY,
        OVER
    } state_e;

    // Signed 11-bit working type so that x - speed never wraps below zero.
    typedef logic signed [10:0] pos_t;

    function automatic pos_t to_pos(input logic [9:0] v);
        return pos_t'({1'b0, v});
    endfunction

endpackage

// File: rtl/paddle_mover.sv
// One paddle: steps per frame tick, clamps to 0..PADDLE_Y_MAX, holds when frozen,
// and returns to the start position on restore.
module paddle_mover
    import pong_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic       up_i,
    input  logic       dn_i,
    input  logic       hold_i,
    input  logic       restore_i,
    output logic [9:0] pos_o
);

    logic [9:0] pos_q, pos_d;
    pos_t       up_pos, dn_pos;

    always_comb begin
        up_pos = to_pos(pos_q) - pos_t'(STEP);
        dn_pos = to_pos(pos_q) + pos_t'(STEP);
        pos_d  = pos_q;
        if (restore_i) begin
            pos_d = 10'(PADDLE_Y_INIT);
        end else if (tick_i && !hold_i && (up_i ^ dn_i)) begin
            if (up_i) begin
                pos_d = (up_pos < 0) ? 10'd0 : up_pos[9:0];
            end else begin
                pos_d = (dn_pos > pos_t'(PADDLE_Y_MAX)) ? 10'(PADDLE_Y_MAX) : dn_pos[9:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= 10'(PADDLE_Y_INIT);
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate pong sequencer: ball motion, bounces, scoring and speed escalation.
// Define PADDLE2_AI_EN to make paddle 2 track the ball instead of following btn2_*.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned PADDLE_STEP    = 4,
    parameter int unsigned SPEED_MIN      = 2,
    parameter int unsigned SPEED_MAX      = 5,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter int unsigned WIN_SCORE      = 5,
    parameter int unsigned SERVE_FRAMES   = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       refresh_tick_i,
    input  logic       btn_start_i,
    input  logic       btn1_up_i,
    input  logic       btn1_dn_i,
    input  logic       btn2_up_i,
    input  logic       btn2_dn_i,
    output logic [9:0] ball_x_o,
    output logic [9:0] ball_y_o,
    output logic [9:0] paddle1_y_o,
    output logic [9:0] paddle2_y_o,
    output logic [3:0] ball_speed_o,
    output logic       game_over_o,
    output logic [3:0] score1_o,
    output logic [3:0] score2_o,
    output logic [1:0] point_pulse_o
);

    state_e      state_q, state_d;
    logic [9:0]  ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic [3:0]  speed_q, speed_d;
    logic [3:0]  score1_q, score1_d, score2_q, score2_d;
    logic [15:0] frame_q, frame_d;
    logic [7:0]  hit_q, hit_d;
    logic [1:0]  point_q, point_d;
    logic        over_q;

    logic [9:0]  paddle1_y, paddle2_y;
    logic        p2_up, p2_dn;
    logic        restart, frozen;

    pos_t        bx, by, spd, nx, ny;
    logic        overlap1, overlap2;
    logic        hit, scored1, scored2;

    assign restart = (state_q == OVER) && btn_start_i;
    assign frozen  = (state_q == OVER);

    always_comb begin
        bx  = to_pos(ball_x_q);
        by  = to_pos(ball_y_q);
        spd = pos_t'({7'd0, speed_q});
        nx  = dx_q ? bx + spd : bx - spd;
        ny  = dy_q ? by + spd : by - spd;
        overlap1 = (by + pos_t'(BALL_SIZE - 1) >= to_pos(paddle1_y) + pos_t'(TOP_MARGIN)) &&
                   (by <= to_pos(paddle1_y) + pos_t'(TOP_MARGIN + PADDLE_H));
        overlap2 = (by + pos_t'(BALL_SIZE - 1) >= to_pos(paddle2_y) + pos_t'(TOP_MARGIN)) &&
                   (by <= to_pos(paddle2_y) + pos_t'(TOP_MARGIN + PADDLE_H));
    end

`ifdef PADDLE2_AI_EN
    localparam int unsigned P2_STEP = PADDLE_STEP / 2;
    pos_t ai_ball, ai_pad;
    assign ai_ball = by - pos_t'(TOP_MARGIN);
    assign ai_pad  = to_pos(paddle2_y) + pos_t'(PADDLE_H / 2);
    assign p2_up   = ai_ball < ai_pad;
    assign p2_dn   = ai_ball > ai_pad;
`else
    localparam int unsigned P2_STEP = PADDLE_STEP;
    assign p2_up = btn2_up_i;
    assign p2_dn = btn2_dn_i;
`endif

    paddle_mover #(
        .STEP(PADDLE_STEP)
    ) u_paddle1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_i   (refresh_tick_i),
        .up_i     (btn1_up_i),
        .dn_i     (btn1_dn_i),
        .hold_i   (frozen),
        .restore_i(restart),
        .pos_o    (paddle1_y)
    );

    paddle_mover #(
        .STEP(P2_STEP)
    ) u_paddle2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_i   (refresh_tick_i),
        .up_i     (p2_up),
        .dn_i     (p2_dn),
        .hold_i   (frozen),
        .restore_i(restart),
        .pos_o    (paddle2_y)
    );

    always_comb begin
        state_d  = state_q;
        ball_x_d = ball_x_q;
        ball_y_d = ball_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        speed_d  = speed_q;
        score1_d = score1_q;
        score2_d = score2_q;
        frame_d  = frame_q;
        hit_d    = hit_q;
        point_d  = 2'b00;
        hit      = 1'b0;
        scored1  = 1'b0;
        scored2  = 1'b0;

        unique case (state_q)
            IDLE: begin
                ball_x_d = 10'(CENTRE_X);
                ball_y_d = 10'(CENTRE_Y);
                if (btn_start_i) begin
                    state_d = SERVE;
                    frame_d = '0;
                end
            end

            SERVE: begin
                ball_x_d = 10'(CENTRE_X);
                ball_y_d = 10'(CENTRE_Y);
                speed_d  = 4'(SPEED_MIN);
                if (refresh_tick_i) begin
                    if (frame_q == 16'(SERVE_FRAMES - 1)) begin
                        state_d = PLAY;
                        dy_d    = ~dy_q;
                        frame_d = '0;
                    end else begin
                        frame_d = frame_q + 16'd1;
                    end
                end
            end

            PLAY: begin
                if (refresh_tick_i) begin
                    if (!dy_q && ny <= pos_t'(BALL_Y_MIN)) begin
                        ball_y_d = 10'(BALL_Y_MIN);
                        dy_d     = 1'b1;
                    end else if (dy_q && ny >= pos_t'(BALL_Y_MAX)) begin
                        ball_y_d = 10'(BALL_Y_MAX);
                        dy_d     = 1'b0;
                    end else begin
                        ball_y_d = ny[9:0];
                    end

                    if (!dx_q && nx <= pos_t'(LEFT_HIT_X)) begin
                        if (overlap1) begin
                            ball_x_d = 10'(LEFT_HIT_X);
                            dx_d     = 1'b1;
                            hit      = 1'b1;
                        end else begin
                            scored2 = 1'b1;
                        end
                    end else if (dx_q && nx >= pos_t'(RIGHT_HIT_X)) begin
                        if (overlap2) begin
                            ball_x_d = 10'(RIGHT_HIT_X);
                            dx_d     = 1'b0;
                            hit      = 1'b1;
                        end else begin
                            scored1 = 1'b1;
                        end
                    end else begin
                        ball_x_d = nx[9:0];
                    end

                    if (hit) begin
                        if (hit_q + 8'd1 == 8'(HITS_PER_LEVEL)) begin
                            hit_d = '0;
                            if (speed_q < 4'(SPEED_MAX)) begin
                                speed_d = speed_q + 4'd1;
                            end
                        end else begin
                            hit_d = hit_q + 8'd1;
                        end
                    end

                    // The next serve heads toward whoever conceded.
                    if (scored1 || scored2) begin
                        speed_d = 4'(SPEED_MIN);
                        hit_d   = '0;
                        if (scored1) begin
                            score1_d   = score1_q + 4'd1;
                            point_d[0] = 1'b1;
                            dx_d       = 1'b1;
                        end else begin
                            score2_d   = score2_q + 4'd1;
                            point_d[1] = 1'b1;
                            dx_d       = 1'b0;
                        end
                        if (score1_d == 4'(WIN_SCORE) || score2_d == 4'(WIN_SCORE)) begin
                            state_d  = OVER;
                            ball_x_d = ball_x_q;
                            ball_y_d = ball_y_q;
                        end else begin
                            state_d  = SERVE;
                            ball_x_d = 10'(CENTRE_X);
                            ball_y_d = 10'(CENTRE_Y);
                            frame_d  = '0;
                        end
                    end
                end
            end

            OVER: begin
                if (btn_start_i) begin
                    state_d  = IDLE;
                    score1_d = '0;
                    score2_d = '0;
                    speed_d  = 4'(SPEED_MIN);
                    dx_d     = 1'b1;
                    ball_x_d = 10'(CENTRE_X);
                    ball_y_d = 10'(CENTRE_Y);
                    hit_d    = '0;
                    frame_d  = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ball_x_q <= 10'(CENTRE_X);
            ball_y_q <= 10'(CENTRE_Y);
            dx_q     <= 1'b1;
            dy_q     <= 1'b1;
            speed_q  <= 4'(SPEED_MIN);
            score1_q <= '0;
            score2_q <= '0;
            frame_q  <= '0;
            hit_q    <= '0;
            point_q  <= '0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            speed_q  <= speed_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            frame_q  <= frame_d;
            hit_q    <= hit_d;
            point_q  <= point_d;
            over_q   <= (state_d == OVER);
        end
    end

    assign ball_x_o      = ball_x_q;
    assign ball_y_o      = ball_y_q;
    assign paddle1_y_o   = paddle1_y;
    assign paddle2_y_o   = paddle2_y;
    assign ball_speed_o  = speed_q;
    assign game_over_o   = over_q;
    assign score1_o      = score1_q;
    assign score2_o      = score2_q;
    assign point_pulse_o = point_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a behavioural game model predicts every update.
module tb_pong_game_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0, start = 1'b0;
    logic       b1u = 1'b0, b1d = 1'b0, b2u = 1'b0, b2d = 1'b0;
    logic [9:0] ball_x, ball_y, paddle1_y, paddle2_y;
    logic [3:0] ball_speed, score1, score2;
    logic       game_over;
    logic [1:0] point_pulse;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .refresh_tick_i(tick),
        .btn_start_i   (start),
        .btn1_up_i     (b1u),
        .btn1_dn_i     (b1d),
        .btn2_up_i     (b2u),
        .btn2_dn_i     (b2d),
        .ball_x_o      (ball_x),
        .ball_y_o      (ball_y),
        .paddle1_y_o   (paddle1_y),
        .paddle2_y_o   (paddle2_y),
        .ball_speed_o  (ball_speed),
        .game_over_o   (game_over),
        .score1_o      (score1),
        .score2_o      (score2),
        .point_pulse_o (point_pulse)
    );

    typedef struct packed {
        logic [9:0] bx, by, p1, p2;
        logic [3:0] spd;
        logic       go;
        logic [3:0] s1, s2;
        logic [1:0] pp;
    } obs_t;

    obs_t sbq[$];
    obs_t obs, e;
    int   n_pass = 0, n_total = 0;

    // Model state: m_st 0=idle 1=serve 2=play 3=over; mdx 1=right, mdy 1=down.
    int m_st, mx, my, ms, m1, m2, mp1, mp2, mcnt, mhit, mpp;
    bit mdx, mdy;

    function automatic obs_t model_out();
        obs_t o;
        o.bx = 10'(mx);  o.by = 10'(my);  o.p1 = 10'(mp1); o.p2 = 10'(mp2);
        o.spd = 4'(ms);  o.go = (m_st == 3); o.s1 = 4'(m1); o.s2 = 4'(m2);
        o.pp = 2'(mpp);
        return o;
    endfunction

    function automatic obs_t dut_out();
        obs_t o;
        o.bx = ball_x; o.by = ball_y; o.p1 = paddle1_y; o.p2 = paddle2_y;
        o.spd = ball_speed; o.go = game_over; o.s1 = score1; o.s2 = score2;
        o.pp = point_pulse;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("ball=(%0d,%0d) pad=(%0d,%0d) spd=%0d go=%0d score=%0d-%0d pp=%0d",
                         o.bx, o.by, o.p1, o.p2, o.spd, o.go, o.s1, o.s2, o.pp);
    endfunction

    task automatic model_reset();
        m_st = 0; mx = 316; my = 248; ms = 2; m1 = 0; m2 = 0;
        mp1 = 191; mp2 = 191; mcnt = 0; mhit = 0; mpp = 0; mdx = 1; mdy = 1;
    endtask

    task automatic model_start();
        mpp = 0;
        if (m_st == 0) begin
            m_st = 1; mcnt = 0;
        end else if (m_st == 3) begin
            m_st = 0; m1 = 0; m2 = 0; mp1 = 191; mp2 = 191; ms = 2; mdx = 1;
            mx = 316; my = 248; mhit = 0; mcnt = 0;
        end
    endtask

    task automatic model_tick(input bit u1, input bit d1, input bit u2, input bit d2);
        int nx, ny, xx, yy, was;
        bit sc1, sc2, hit;
        was = m_st; mpp = 0;
        if (m_st == 2) begin
            nx = mdx ? mx + ms : mx - ms;
            ny = mdy ? my + ms : my - ms;
            yy = ny;
            if (!mdy && ny <= 25) begin yy = 25; mdy = 1; end
            else if (mdy && ny >= 472) begin yy = 472; mdy = 0; end
            xx = nx; sc1 = 0; sc2 = 0; hit = 0;
            if (!mdx && nx <= 41) begin
                if (my + 7 >= mp1 + 25 && my <= mp1 + 97) begin xx = 41; mdx = 1; hit = 1; end
                else sc2 = 1;
            end else if (mdx && nx >= 592) begin
                if (my + 7 >= mp2 + 25 && my <= mp2 + 97) begin xx = 592; mdx = 0; hit = 1; end
                else sc1 = 1;
            end
            if (hit) begin
                mhit++;
                if (mhit == 4) begin mhit = 0; if (ms < 5) ms++; end
            end
            if (sc1 || sc2) begin
                ms = 2; mhit = 0;
                if (sc1) begin m1++; mpp = 1; mdx = 1; end
                else begin m2++; mpp = 2; mdx = 0; end
                if (m1 == 5 || m2 == 5) m_st = 3;
                else begin m_st = 1; mx = 316; my = 248; mcnt = 0; end
            end else begin
                mx = xx; my = yy;
            end
        end else if (m_st == 1) begin
            if (mcnt == 59) begin m_st = 2; mdy = !mdy; mcnt = 0; end
            else mcnt++;
        end
        if (was != 3) begin
            if (u1 && !d1) mp1 = (mp1 - 4 < 0) ? 0 : mp1 - 4;
            if (d1 && !u1) mp1 = (mp1 + 4 > 382) ? 382 : mp1 + 4;
            if (u2 && !d2) mp2 = (mp2 - 4 < 0) ? 0 : mp2 - 4;
            if (d2 && !u2) mp2 = (mp2 + 4 > 382) ? 382 : mp2 + 4;
        end
    endtask

    // Drive one frame tick and queue the predicted result; sample is on the next negedge.
    task automatic drive_tick(input bit u1, input bit d1, input bit u2, input bit d2);
        @(negedge clk);
        b1u = u1; b1d = d1; b2u = u2; b2d = d2; tick = 1'b1;
        model_tick(u1, d1, u2, d2);
        sbq.push_back(model_out());
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic drive_start();
        @(negedge clk);
        start = 1'b1;
        model_start();
        sbq.push_back(model_out());
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        obs = dut_out(); e = model_out();
        n_total++;
        if (obs !== e) $display("FAIL reset: got %s want %s", fmt(obs), fmt(e));
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_paddle_saturation();
        for (int i = 0; i < 60; i++) begin
            drive_tick(1, 0, 0, 1);
            obs = dut_out(); e = sbq.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL paddle_hold[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            else n_pass++;
        end
        n_total++;
        if (paddle1_y !== 10'd0 || paddle2_y !== 10'd382)
            $display("FAIL paddle_sat: got %0d/%0d want 0/382", paddle1_y, paddle2_y);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            drive_tick(1, 1, 1, 1);
            obs = dut_out(); e = sbq.pop_front();
            n_total++;
            if (obs !== e || paddle1_y !== 10'd0 || paddle2_y !== 10'd382)
                $display("FAIL paddle_both[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            else n_pass++;
        end
    endtask

    task automatic test_serve();
        drive_start();
        obs = dut_out(); e = sbq.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL serve_start: got %s want %s", fmt(obs), fmt(e));
        else n_pass++;
        for (int i = 1; i <= 61; i++) begin
            drive_tick(0, 0, 0, 0);
            obs = dut_out(); e = sbq.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL serve_tick[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            else n_pass++;
            if (i == 60) begin
                n_total++;
                if (ball_x !== 10'd316 || ball_y !== 10'd248)
                    $display("FAIL serve_hold: got (%0d,%0d) want (316,248)", ball_x, ball_y);
                else n_pass++;
            end
        end
        n_total++;
        if (ball_x !== 10'd318 || ball_y !== 10'd246)
            $display("FAIL serve_first_move: got (%0d,%0d) want (318,246)", ball_x, ball_y);
        else n_pass++;
    endtask

    task automatic test_reset_mid_play();
        for (int i = 0; i < 20; i++) begin
            drive_tick(0, 0, 0, 0);
            obs = dut_out(); e = sbq.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL preplay[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        obs = dut_out(); e = model_out();
        n_total++;
        if (obs !== e) $display("FAIL reset_async: got %s want %s", fmt(obs), fmt(e));
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_tick(0, 0, 0, 0);
        obs = dut_out(); e = sbq.pop_front();
        n_total++;
        if (obs !== e || ball_x !== 10'd316)
            $display("FAIL reset_idle: got %s want %s", fmt(obs), fmt(e));
        else n_pass++;
    endtask

    // Paddles chase the ball so rallies build up hits and speed.
    task automatic test_rally();
        int pc1, pc2, yc;
        bit u1, d1, u2, d2;
        drive_start();
        void'(sbq.pop_front());
        for (int i = 0; i < 2500; i++) begin
            if (m_st == 3) begin
                drive_start(); void'(sbq.pop_front());
                drive_start(); void'(sbq.pop_front());
            end
            yc = my + 4; pc1 = mp1 + 61; pc2 = mp2 + 61;
            u1 = yc < pc1 - 6; d1 = yc > pc1 + 6;
            u2 = yc < pc2 - 6; d2 = yc > pc2 + 6;
            drive_tick(u1, d1, u2, d2);
            obs = dut_out(); e = sbq.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL rally[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            else n_pass++;
            if (e.pp != 2'b00) begin
                @(negedge clk);
                n_total++;
                if (point_pulse !== 2'b00)
                    $display("FAIL pulse_width[%0d]: got %0d want 0", i, point_pulse);
                else n_pass++;
            end
        end
    endtask

    task automatic test_game_over();
        int guard;
        logic [9:0] fx, fy;
        if (m_st == 3) begin drive_start(); void'(sbq.pop_front()); end
        if (m_st == 0) begin drive_start(); void'(sbq.pop_front()); end
        guard = 0;
        while (m_st != 3 && guard < 6000) begin
            drive_tick(1, 0, 1, 0);
            obs = dut_out(); e = sbq.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL to_over[%0d]: got %s want %s", guard, fmt(obs), fmt(e));
            else n_pass++;
            guard++;
        end
        n_total++;
        if (m_st != 3 || game_over !== 1'b1 || (score1 !== 4'd5 && score2 !== 4'd5))
            $display("FAIL game_over: got go=%0d score=%0d-%0d want go=1 and a score of 5",
                     game_over, score1, score2);
        else n_pass++;
        fx = ball_x; fy = ball_y;
        for (int i = 0; i < 5; i++) begin
            drive_tick(0, 1, 0, 1);
            obs = dut_out(); e = sbq.pop_front();
            n_total++;
            if (obs !== e || ball_x !== fx || ball_y !== fy)
                $display("FAIL over_frozen[%0d]: got %s want %s", i, fmt(obs), fmt(e));
            else n_pass++;
        end
        drive_start();
        obs = dut_out(); e = sbq.pop_front();
        n_total++;
        if (obs !== e || score1 !== 4'd0 || score2 !== 4'd0 || game_over !== 1'b0 ||
            paddle1_y !== 10'd191)
            $display("FAIL restart: got %s want %s", fmt(obs), fmt(e));
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_paddle_saturation();
        test_serve();
        test_reset_mid_play();
        test_rally();
        test_game_over();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
